tarhi_boot_loader: RTL and testbench
====================================

// Module: tarhi_boot_loader
// PURPOSE
//  Byte-stream program loader between the tarhi core and mem. After reset it
//  holds the core stopped and receives a framed image: sync, address, count,
//  words, checksum. It writes the words into mem, then releases the core and
//  passes the core's mem request signals through to mem unchanged.
//  Read data (mem -> core) does not pass through this block.
// PARAMETERS
//  SYNC_BYTE  8'hA5  frame start marker; other bytes in IDLE are discarded
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  reset          in   1   asynchronous, active-low reset
//  rx_valid       in   1   rx_data holds a byte
//  rx_data        in   8   incoming byte
//  rx_ready       out  1   byte consumed on a clk edge where rx_valid & rx_ready
//  cpu_mem_enable in   1   core request (used in RUN only)
//  cpu_mem_write  in   1   core write strobe
//  cpu_mem_addr   in   24  core address
//  cpu_mem_dout   in   32  core write data
//  mem_enable     out  1   to mem
//  mem_write      out  1   to mem
//  mem_addr       out  24  to mem
//  mem_dout       out  32  to mem write data
//  cpu_run        out  1   1 = core may run (drives the core's reset release)
//  busy           out  1   frame in progress (HDR/DATA/WRITE/CHK)
//  done           out  1   image loaded OK (sticky until reset)
//  error          out  1   checksum mismatch (sticky until reset)
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, rx_ready=1, mem_enable=0, mem_write=0,
//   mem_addr=0, mem_dout=0, cpu_run=0, busy=0, done=0, error=0, chk=0.
//  Frame: SYNC, A[23:16], A[15:8], A[7:0], N[15:8], N[7:0], N words of 4 bytes
//   each (MSB first), then C. C = XOR of the 5 header bytes and all data bytes.
//  IDLE: rx_ready=1. SYNC_BYTE -> HDR; any other byte is dropped.
//  HDR: takes 5 bytes, loads addr and count, folds each byte into chk.
//   After the 5th byte: N==0 -> CHK, else -> DATA.
//  DATA: shifts in 4 bytes. After the 4th byte -> WRITE.
//  WRITE: exactly 1 cycle. rx_ready=0, mem_enable=1, mem_write=1,
//   mem_addr=addr, mem_dout=word. Then addr += 1 (mod 2^24, FFFFFF wraps to 0)
//   and count -= 1. count==0 -> CHK, else -> DATA.
//  CHK: takes 1 byte. byte==chk -> RUN (done=1, cpu_run=1); else -> ERROR (error=1).
//  RUN: rx_ready=0. mem_* = cpu_mem_* combinationally (zero latency).
//   Stays in RUN until reset.
//  ERROR: rx_ready=0, mem_enable=0, cpu_run=0. Stays in ERROR until reset.
//  rx_ready is low only in WRITE, RUN and ERROR. A byte presented while
//   rx_ready=0 is not consumed and must be held by the source.
//  At most one byte is consumed per cycle. In WRITE the next byte waits one cycle.
//  mem_enable and mem_write are 0 in every load state except WRITE.
//   Core requests are ignored until RUN.
//  Reset asserted mid-frame aborts at once: words already written stay in mem;
//   the frame restarts from IDLE.
// TESTING
//  1. A5 00 01 00 00 02 11223344 55667788 + correct C -> writes 11223344@000100,
//     55667788@000101; then done=1, cpu_run=1.
//  2. The same frame with C xor 01 -> both writes still occur; error=1,
//     cpu_run=0, rx_ready=0 until reset.
//  3. Garbage 00 FF 3C, then A5 with N=0 and C=XOR(hdr) -> no writes; done=1.
//  4. Address FFFFFF, N=2 -> writes at FFFFFF then 000000 (wrap).
//  5. In RUN, cpu_mem_addr=000123 with enable/write=1 -> mem_* mirror the core
//     in the same cycle. An rx byte is not consumed.
//  6. Pulse reset low after the 3rd data byte -> all outputs at reset values;
//     a full new frame then loads correctly. Also hold rx_valid back-to-back
//     through WRITE and check no byte is lost.

Source files
------------

// File: rtl/tarhi_boot_loader.sv
// tarhi_boot_loader
//   Byte-stream program loader that sits between the tarhi core and memory.
//   After reset the core is held stopped while a framed image is received:
//     SYNC, A[23:16], A[15:8], A[7:0], N[15:8], N[7:0], N x 4-byte words
//     (MSB first), C.
//   Here C is the XOR of the five header bytes and all data bytes.
//   Each completed word is written to memory in a single WRITE cycle. A good
//   checksum releases the core, and the core's memory requests then pass
//   straight through to memory. A bad checksum locks the block in ERROR
//   until reset.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   rx_valid, rx_data, rx_ready byte stream in (consumed on valid & ready)
//   cpu_mem_*                   core memory request (honoured in RUN only)
//   mem_*                       memory request out
//   cpu_run                     core may run
//   busy                        frame in progress (HDR/DATA/WRITE/CHK)
//   done, error                 sticky load result
module tarhi_boot_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        cpu_mem_enable,
    input  logic        cpu_mem_write,
    input  logic [23:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_dout,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_dout,
    output logic        cpu_run,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StWrite,
        StChk,
        StRun,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  chk_q, chk_d;

    logic accept;

    assign accept = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hdr_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            addr_q     <= 24'd0;
            count_q    <= 16'd0;
            word_q     <= 32'd0;
            chk_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            word_q     <= word_d;
            chk_q      <= chk_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        count_d    = count_q;
        word_d     = word_q;
        chk_d      = chk_q;

        unique case (state_q)
            StIdle: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d   = StHdr;
                    hdr_cnt_d = 3'd0;
                    chk_d     = 8'd0; // sync byte is not part of the checksum
                end
            end
            StHdr: begin
                if (accept) begin
                    chk_d     = chk_q ^ rx_data;
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    case (hdr_cnt_q)
                        3'd0: addr_d[23:16] = rx_data;
                        3'd1: addr_d[15:8]  = rx_data;
                        3'd2: addr_d[7:0]   = rx_data;
                        3'd3: count_d[15:8] = rx_data;
                        default: begin
                            count_d[7:0] = rx_data;
                            byte_cnt_d   = 2'd0;
                            // Decide on the full count including the byte being taken now
                            if ({count_q[15:8], rx_data} == 16'd0) begin
                                state_d = StChk;
                            end else begin
                                state_d = StData;
                            end
                        end
                    endcase
                end
            end
            StData: begin
                if (accept) begin
                    word_d     = {word_q[23:0], rx_data};
                    chk_d      = chk_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d     = addr_q + 24'd1; // wraps FFFFFF -> 000000
                count_d    = count_q - 16'd1;
                byte_cnt_d = 2'd0;
                if (count_q == 16'd1) begin
                    state_d = StChk;
                end else begin
                    state_d = StData;
                end
            end
            StChk: begin
                if (accept) begin
                    if (rx_data == chk_q) begin
                        state_d = StRun;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StRun:   state_d = StRun;
            StError: state_d = StError;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        rx_ready   = 1'b1;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 24'd0;
        mem_dout   = 32'd0;

        unique case (state_q)
            StWrite: begin
                rx_ready   = 1'b0;
                mem_enable = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = addr_q;
                mem_dout   = word_q;
            end
            StRun: begin
                rx_ready   = 1'b0;
                mem_enable = cpu_mem_enable;
                mem_write  = cpu_mem_write;
                mem_addr   = cpu_mem_addr;
                mem_dout   = cpu_mem_dout;
            end
            StError: begin
                rx_ready = 1'b0;
            end
            default: begin
                rx_ready = 1'b1;
            end
        endcase
    end

    assign cpu_run = (state_q == StRun);
    assign done    = (state_q == StRun);
    assign error   = (state_q == StError);
    assign busy    = (state_q == StHdr) || (state_q == StData) ||
                     (state_q == StWrite) || (state_q == StChk);

endmodule

// File: tb/tb_tarhi_boot_loader.sv
// Testbench for tarhi_boot_loader: directed frames with a scoreboard of
// expected memory writes, checked whenever the loader drives a write.
module tb_tarhi_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cpu_mem_enable;
    logic        cpu_mem_write;
    logic [23:0] cpu_mem_addr;
    logic [31:0] cpu_mem_dout;
    logic        mem_enable;
    logic        mem_write;
    logic [23:0] mem_addr;
    logic [31:0] mem_dout;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [55:0] exp_q[$];   // {addr, data} of expected load writes
    logic [31:0] img[4];

    always #5 clk = ~clk;

    tarhi_boot_loader dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .cpu_mem_enable (cpu_mem_enable),
        .cpu_mem_write  (cpu_mem_write),
        .cpu_mem_addr   (cpu_mem_addr),
        .cpu_mem_dout   (cpu_mem_dout),
        .mem_enable     (mem_enable),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .cpu_run        (cpu_run),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {done, cpu_run, error, busy, rx_ready}
    task automatic status(input string tag, input logic [4:0] exp);
        chk(tag, 64'({done, cpu_run, error, busy, rx_ready}), 64'(exp));
    endtask

    // Any memory activity outside RUN must match the next scoreboard entry.
    task automatic check_mem();
        logic [55:0] e;
        if ((mem_enable || mem_write) && !cpu_run) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = 'x;
            end
            chk("write_strobes", 64'({mem_enable, mem_write}), 64'(2'b11));
            chk("write_addr", 64'(mem_addr), 64'(e[55:32]));
            chk("write_data", 64'(mem_dout), 64'(e[31:0]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_mem();
    endtask

    task automatic check_reset_vals();
        chk("reset_outputs",
            64'({rx_ready, mem_enable, mem_write, mem_addr, mem_dout,
                 cpu_run, busy, done, error}),
            64'({1'b1, 62'd0}));
    endtask

    // Present a byte and hold it until consumed; rx_valid stays high afterwards.
    task automatic send_byte(input logic [7:0] b);
        bit taken;
        taken    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 8 && !taken; i++) begin
            taken = rx_ready;
            tick();
        end
        if (!taken) chk("rx_accept_timeout", 64'(rx_ready), 64'd1);
    endtask

    task automatic send_frame(input logic [23:0] a, input logic [15:0] n,
                              input logic [7:0] cflip);
        logic [7:0]  c;
        logic [23:0] wa;
        c  = 8'd0;
        wa = a;
        send_byte(8'hA5);
        send_byte(a[23:16]); c ^= a[23:16];
        send_byte(a[15:8]);  c ^= a[15:8];
        send_byte(a[7:0]);   c ^= a[7:0];
        send_byte(n[15:8]);  c ^= n[15:8];
        send_byte(n[7:0]);   c ^= n[7:0];
        for (int w = 0; w < int'(n); w++) begin
            exp_q.push_back({wa, img[w]});
            wa = wa + 24'd1;
            for (int k = 3; k >= 0; k--) begin
                send_byte(img[w][k*8 +: 8]);
                c ^= img[w][k*8 +: 8];
            end
        end
        send_byte(c ^ cflip);
        rx_valid = 1'b0;
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        rx_valid       = 1'b0;
        rx_data        = 8'h00;
        cpu_mem_enable = 1'b0;
        cpu_mem_write  = 1'b0;
        cpu_mem_addr   = 24'd0;
        cpu_mem_dout   = 32'd0;
        #3 check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: two-word image at 000100 with a correct checksum
        img[0] = 32'h11223344;
        img[1] = 32'h55667788;
        send_frame(24'h000100, 16'd2, 8'h00);
        status("t1_loaded", 5'b11000);

        // 5: passthrough in RUN, rx stream stalled
        cpu_mem_enable = 1'b1;
        cpu_mem_write  = 1'b1;
        cpu_mem_addr   = 24'h000123;
        cpu_mem_dout   = 32'hDEADBEEF;
        #1;
        chk("run_passthrough_wr",
            64'({mem_enable, mem_write, mem_addr, mem_dout}),
            64'({1'b1, 1'b1, 24'h000123, 32'hDEADBEEF}));
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        tick();
        tick();
        cpu_mem_write = 1'b0;
        cpu_mem_addr  = 24'hABCDEF;
        #1;
        chk("run_passthrough_rd",
            64'({mem_enable, mem_write, mem_addr, mem_dout}),
            64'({1'b1, 1'b0, 24'hABCDEF, 32'hDEADBEEF}));
        status("t5_run_stalled", 5'b11000);
        cpu_mem_enable = 1'b0;
        cpu_mem_addr   = 24'd0;
        cpu_mem_dout   = 32'd0;

        // 2: same frame, corrupted checksum; core requests must be ignored
        apply_reset();
        cpu_mem_enable = 1'b1;
        cpu_mem_write  = 1'b1;
        cpu_mem_addr   = 24'h000777;
        send_frame(24'h000100, 16'd2, 8'h01);
        status("t2_error", 5'b00100);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        tick();
        tick();
        tick();
        status("t2_error_sticky", 5'b00100);
        chk("t2_mem_idle", 64'({mem_enable, mem_write}), 64'd0);

        // 3: garbage ahead of sync, then an empty image
        apply_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        rx_valid = 1'b0;
        status("t3_garbage_idle", 5'b00001);
        send_frame(24'h001000, 16'd0, 8'h00);
        status("t3_empty_loaded", 5'b11000);
        cpu_mem_enable = 1'b0;
        cpu_mem_write  = 1'b0;
        cpu_mem_addr   = 24'd0;

        // 4: address wrap
        apply_reset();
        img[0] = 32'hCAFEF00D;
        img[1] = 32'h0BADBEEF;
        send_frame(24'hFFFFFF, 16'd2, 8'h00);
        status("t4_wrap_loaded", 5'b11000);

        // 6: abort after the third data byte, then a clean back-to-back reload
        apply_reset();
        img[0] = 32'h01020304;
        img[1] = 32'hA0B0C0D0;
        img[2] = 32'h00000000;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        status("t6_mid_frame", 5'b00011);
        apply_reset();
        send_frame(24'h000200, 16'd3, 8'h00);
        status("t6_reloaded", 5'b11000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
